axi_stream_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream valid/ready stream channel among NUM_REQ upstream requesters with packet-granular locking. A grant is held from the first beat to the beat marked last, so packets are never interleaved. Accepted beats pass through a built-in two-entry output slice (main register plus skid register), so every output and every upstream ready is driven from a register. The block sits in front of any single-consumer datapath stage that several stream sources must share.

---
 rtl/axi_stream_rr_arbiter_if.sv | 18 +
 rtl/axi_stream_rr_arbiter.sv | 82 ++++++++
 tb/tb_axi_stream_rr_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_rr_arbiter_if.sv
// axi_stream_rr_arbiter_if: requester-side and downstream stream signals of the round-robin arbiter
interface axi_stream_rr_arbiter_if #(
   parameter int DWIDTH  = 8,
   parameter int NUM_REQ = 4,
   parameter int IDW     = 3
);
   logic [NUM_REQ-1:0]        valid_i;
   logic [NUM_REQ*DWIDTH-1:0] data_i;
   logic [NUM_REQ-1:0]        last_i;
   logic [NUM_REQ-1:0]        ready_o;
   logic                      valid_o;
   logic [DWIDTH-1:0]         data_o;
   logic                      last_o;
   logic [IDW-1:0]            id_o;
   logic                      ready_i;
   modport slave  (input valid_i, data_i, last_i, ready_i, output ready_o, valid_o, data_o, last_o, id_o);
   modport master (output valid_i, data_i, last_i, ready_i, input ready_o, valid_o, data_o, last_o, id_o);
endinterface

// File: rtl/axi_stream_rr_arbiter.sv
// axi_stream_rr_arbiter: packet-locked round-robin stream arbiter with a registered two-entry output slice
module axi_stream_rr_arbiter #(
   parameter int DWIDTH  = 8,
   parameter int NUM_REQ = 4,
   parameter int IDW     = 3
) (
   input logic                    aclk_i,
   input logic                    areset_i,
   axi_stream_rr_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t             r_state, w_state_n;
   logic [IDW-1:0]     r_gnt, r_ptr, w_sel, w_gnt_n;
   logic [IDW:0]       w_sh, w_off, w_sum;
   logic [NUM_REQ-1:0] w_rot, r_ready, w_rdy_n;
   logic               r_mv, r_sv, r_ml, r_sl;
   logic [DWIDTH-1:0]  r_md, r_sd, w_beat;
   logic [IDW-1:0]     r_mid, r_sid;
   logic               w_any, w_acc, w_xfer, w_last, w_sv_n;
   // rotate so bit 0 is requester ptr+1; the lowest set bit is the next in round-robin order
   always_comb begin
      w_sh  = {1'b0, r_ptr} + 1'b1;
      w_rot = NUM_REQ'({bus.valid_i, bus.valid_i} >> w_sh);
      w_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (w_rot[i]) w_off = (IDW+1)'(i);
      w_sum = w_sh + w_off;
      w_sel = IDW'(w_sum >= (IDW+1)'(NUM_REQ) ? w_sum - (IDW+1)'(NUM_REQ) : w_sum);
   end
   always_comb begin
      w_beat = '0;
      w_last = 1'b0;
      for (int k = 0; k < NUM_REQ; k++)
         if (r_gnt == IDW'(k)) begin
            w_beat = bus.data_i[k*DWIDTH +: DWIDTH];
            w_last = bus.last_i[k];
         end
   end
   assign w_any     = |bus.valid_i;
   assign w_acc     = |(r_ready & bus.valid_i);
   assign w_xfer    = r_mv & bus.ready_i;
   assign w_state_n = (r_state == IDLE) ? (w_any ? LOCKED : IDLE) : ((w_acc && w_last) ? IDLE : LOCKED);
   assign w_gnt_n   = (r_state == IDLE && w_any) ? w_sel : r_gnt;
   assign w_sv_n    = ~w_xfer & (r_sv | (w_acc & r_mv));
   // ready is precomputed from next-cycle state so the upstream ready is a flop
   always_comb begin
      w_rdy_n = '0;
      for (int k = 0; k < NUM_REQ; k++)
         w_rdy_n[k] = (w_state_n == LOCKED) && !w_sv_n && (w_gnt_n == IDW'(k));
   end
   always_ff @(posedge aclk_i or posedge areset_i) begin
      if (areset_i) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_ptr   <= IDW'(NUM_REQ - 1);
         r_ready <= '0;
         r_mv    <= 1'b0;
         r_sv    <= 1'b0;
         r_md    <= '0;
         r_ml    <= 1'b0;
         r_mid   <= '0;
         r_sd    <= '0;
         r_sl    <= 1'b0;
         r_sid   <= '0;
      end else begin
         r_state <= w_state_n;
         r_gnt   <= w_gnt_n;
         r_ready <= w_rdy_n;
         r_sv    <= w_sv_n;
         r_mv    <= (w_xfer || !r_mv) ? (r_sv | w_acc) : 1'b1;
         if (w_acc && w_last) r_ptr <= r_gnt;
         if (!w_xfer && w_acc && r_mv) {r_sd, r_sl, r_sid} <= {w_beat, w_last, r_gnt};
         if (w_xfer && r_sv) {r_md, r_ml, r_mid} <= {r_sd, r_sl, r_sid};
         else if ((w_xfer || !r_mv) && w_acc) {r_md, r_ml, r_mid} <= {w_beat, w_last, r_gnt};
      end
   end
   assign bus.ready_o = r_ready;
   assign bus.valid_o = r_mv;
   assign bus.data_o  = r_md;
   assign bus.last_o  = r_ml;
   assign bus.id_o    = r_mid;
endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// tb_axi_stream_rr_arbiter: directed cycle-by-cycle checks of arbitration, locking, backpressure and reset
module tb_axi_stream_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   axi_stream_rr_arbiter_if #(.DWIDTH(8), .NUM_REQ(4), .IDW(3)) bus ();
   axi_stream_rr_arbiter #(.DWIDTH(8), .NUM_REQ(4), .IDW(3)) dut (
      .aclk_i(clk), .areset_i(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   logic [3:0] t3_rdy [12] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                               4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
   logic [2:0] t3_id  [12] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd1};
   logic [7:0] t4_din [13] = '{8'h30, 8'h30, 8'h31, 8'h32, 8'h33, 8'h33, 8'h33,
                               8'h33, 8'h33, 8'h34, 8'h35, 8'h00, 8'h00};
   logic       t4_rdi [13] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   logic [3:0] t4_rdy [13] = '{4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
   logic       t4_v   [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   logic [7:0] t4_d   [13] = '{8'h00, 8'h00, 8'h30, 8'h31, 8'h31, 8'h31, 8'h31,
                               8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h00};
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l,
                          input logic [2:0] id, input logic [3:0] rdy);
      chk({tag, "_valid"}, 32'(bus.valid_o), 32'(v));
      chk({tag, "_ready"}, 32'(bus.ready_o), 32'(rdy));
      if (v) begin
         chk({tag, "_data"}, 32'(bus.data_o), 32'(d));
         chk({tag, "_last"}, 32'(bus.last_o), 32'(l));
         chk({tag, "_id"}, 32'(bus.id_o), 32'(id));
      end
   endtask
   task automatic put(input int k, input logic [7:0] d, input logic l);
      bus.data_i[k*8 +: 8] = d;
      bus.last_i[k] = l;
   endtask
   initial begin
      bus.valid_i = '0;
      bus.data_i  = '0;
      bus.last_i  = '0;
      bus.ready_i = 1'b1;
      tick();
      tick();
      chk_out("reset", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      chk("reset_data", 32'(bus.data_o), 32'h0);
      chk("reset_id", 32'(bus.id_o), 32'h0);
      // single 3-beat packet from requester 1
      rst = 1'b0;
      bus.valid_i = 4'b0010;
      put(1, 8'hA0, 1'b0);
      chk_out("t1_c0", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      tick();
      chk_out("t1_c1", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0010);
      tick();
      put(1, 8'hA1, 1'b0);
      chk_out("t1_c2", 1'b1, 8'hA0, 1'b0, 3'd1, 4'b0010);
      tick();
      put(1, 8'hA2, 1'b1);
      chk_out("t1_c3", 1'b1, 8'hA1, 1'b0, 3'd1, 4'b0010);
      tick();
      bus.valid_i = 4'b0000;
      put(1, 8'h00, 1'b0);
      chk_out("t1_c4", 1'b1, 8'hA2, 1'b1, 3'd1, 4'b0000);
      tick();
      chk_out("t1_c5", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      // requesters 0 and 2 after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.valid_i = 4'b0101;
      put(0, 8'h10, 1'b1);
      put(2, 8'h20, 1'b1);
      chk_out("t2_d0", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      tick();
      chk_out("t2_d1", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0001);
      tick();
      bus.valid_i = 4'b0100;
      chk_out("t2_d2", 1'b1, 8'h10, 1'b1, 3'd0, 4'b0000);
      tick();
      chk_out("t2_d3", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0100);
      tick();
      bus.valid_i = 4'b0000;
      chk_out("t2_d4", 1'b1, 8'h20, 1'b1, 3'd2, 4'b0000);
      tick();
      chk_out("t2_d5", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      // all four requesters continuously offering single-beat packets
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.valid_i = 4'b1111;
      for (int k = 0; k < 4; k++) put(k, 8'hC0 + 8'(k), 1'b1);
      chk_out("t3_e0", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 12) bus.valid_i = 4'b0000;
         chk_out($sformatf("t3_e%0d", i), (i % 2) == 0, 8'hC0 + 8'(t3_id[i-1]), 1'b1,
                 t3_id[i-1], t3_rdy[i-1]);
      end
      tick();
      chk_out("t3_e13", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      // requester 3 streams 6 beats with downstream stalled for cycles 3-6
      bus.valid_i = 4'b1000;
      put(3, t4_din[0], 1'b0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         bus.valid_i = (i <= 10) ? 4'b1000 : 4'b0000;
         put(3, t4_din[i], i == 10);
         bus.ready_i = t4_rdi[i];
         chk_out($sformatf("t4_f%0d", i), t4_v[i], t4_d[i], i == 11, 3'd3, t4_rdy[i]);
      end
      // requester 2 pauses mid-packet while requester 1 waits
      bus.valid_i = 4'b0100;
      put(2, 8'h50, 1'b0);
      tick();
      bus.valid_i = 4'b0110;
      put(1, 8'h60, 1'b1);
      chk_out("t5_g1", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0100);
      tick();
      bus.valid_i = 4'b0010;
      chk_out("t5_g2", 1'b1, 8'h50, 1'b0, 3'd2, 4'b0100);
      tick();
      chk_out("t5_g3", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0100);
      tick();
      bus.valid_i = 4'b0110;
      put(2, 8'h51, 1'b1);
      chk_out("t5_g4", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0100);
      tick();
      bus.valid_i = 4'b0010;
      chk_out("t5_g5", 1'b1, 8'h51, 1'b1, 3'd2, 4'b0000);
      tick();
      chk_out("t5_g6", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0010);
      tick();
      bus.valid_i = 4'b0000;
      chk_out("t5_g7", 1'b1, 8'h60, 1'b1, 3'd1, 4'b0000);
      // fill both slice entries, then reset asynchronously mid-packet
      tick();
      bus.valid_i = 4'b0001;
      bus.ready_i = 1'b0;
      put(0, 8'h70, 1'b0);
      chk_out("t6_h0", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      tick();
      chk_out("t6_h1", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0001);
      tick();
      put(0, 8'h71, 1'b0);
      chk_out("t6_h2", 1'b1, 8'h70, 1'b0, 3'd0, 4'b0001);
      tick();
      bus.valid_i = 4'b0110;
      put(0, 8'h72, 1'b0);
      put(1, 8'h81, 1'b1);
      put(2, 8'h82, 1'b1);
      chk_out("t6_h3", 1'b1, 8'h70, 1'b0, 3'd0, 4'b0000);
      #2 rst = 1'b1;
      #1;
      chk_out("t6_rst", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0000);
      chk("t6_rst_data", 32'(bus.data_o), 32'h0);
      chk("t6_rst_last", 32'(bus.last_o), 32'h0);
      #1 rst = 1'b0;
      bus.ready_i = 1'b1;
      tick();
      chk_out("t6_i1", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0010);
      tick();
      bus.valid_i = 4'b0100;
      chk_out("t6_i2", 1'b1, 8'h81, 1'b1, 3'd1, 4'b0000);
      tick();
      chk_out("t6_i3", 1'b0, 8'h00, 1'b0, 3'd0, 4'b0100);
      tick();
      bus.valid_i = 4'b0000;
      chk_out("t6_i4", 1'b1, 8'h82, 1'b1, 3'd2, 4'b0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
